// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared state encoding and default sizes for the UART TX.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_CLKS_PER_BIT = 16;

  // PARITY is always encoded; it is only reachable in parity-enabled builds.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_baud_tick                                               |
// | Description : Bit-period counter; tick marks the last cycle of each bit.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_mem_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_mem_tx                                                  |
// | Description : Reads a block of words from shared memory and sends each as  |
// |               a UART frame. Define UART_TX_PARITY_EN for an even parity bit.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_mem_tx
  import uart_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  tx
);

  localparam int c_BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [c_BIT_W-1:0]    c_LAST_BIT  = c_BIT_W'(WIDTH - 1);

  tx_state_t             r_state;
  tx_state_t             w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [WIDTH-1:0]      r_shift;
  logic [c_BIT_W-1:0]    r_bit;
  logic                  r_tx;
  logic                  r_done;
  logic                  w_tx_next;
  logic                  w_tick;
  logic                  w_clr;
`ifdef UART_TX_PARITY_EN
  logic                  r_par;
`endif

  // Restarting the bit counter on every state entry keeps bit edges aligned.
  assign w_clr = (w_next != r_state);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (start && (len != '0)) w_next = FETCH;
      FETCH:  w_next = LOAD;
      LOAD:   w_next = START;
      START:  if (w_tick) w_next = DATA;
      DATA: begin
        if (w_tick && (r_bit == c_LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
      PARITY: if (w_tick) w_next = STOP;
      STOP:   if (w_tick) w_next = (r_remaining != '0) ? FETCH : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    mem_re    = (r_state == FETCH);
    w_tx_next = 1'b1;
    case (r_state)
      START:  w_tx_next = 1'b0;
      DATA:   w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: w_tx_next = r_par;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_shift     <= '0;
      r_bit       <= '0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_tx   <= w_tx_next;
      r_done <= ((r_state == IDLE) && start && (len == '0)) ||
                ((r_state == STOP) && w_tick && (r_remaining == '0));
      case (r_state)
        IDLE: begin
          if (start && (len != '0)) begin
            r_addr      <= start_addr;
            r_remaining <= len;
          end
        end
        LOAD: begin
          r_shift     <= mem_rdata;
          r_addr      <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
          r_bit       <= '0;
`ifdef UART_TX_PARITY_EN
          r_par       <= ^mem_rdata;
`endif
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            r_bit   <= r_bit + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_raddr = r_addr;
  assign tx        = r_tx;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_mem_tx                                               |
// | Description : Directed, table-driven self-checking bench for uart_mem_tx.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_mem_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // start-bit to start-bit spacing for back-to-back frames
  localparam int PERIOD = NBITS * CPB + 2;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       start      = 1'b0;
  logic [3:0] start_addr = '0;
  logic [4:0] len        = '0;
  logic       busy;
  logic       done;
  logic       mem_re;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic       tx;

  uart_mem_tx #(
    .WIDTH        (8),
    .DEPTH        (16),
    .ADDR_WIDTH   (4),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .mem_re     (mem_re),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:15];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  typedef struct {
    logic [3:0]  addr;
    logic [4:0]  len;
    logic [31:0] data;
    int          inj;
  } vec_t;

  vec_t vecs [6];
  logic tx_log [0:255];
  int   last_done_at;
  int   n_checks;
  int   n_pass;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic load_mem(input logic [3:0] a, input logic [4:0] l, input logic [31:0] d);
    logic [3:0] ad;
    for (int i = 0; i < int'(l); i++) begin
      ad = a + 4'(i);
      mem[ad] = d[8*i +: 8];
    end
  endtask

  // Issues a start, samples every cycle after acceptance and checks the result.
  task automatic run_xfer(input string name, input logic [3:0] a, input logic [4:0] l,
                          input logic [31:0] d, input int inj);
    bit         exp_tx[$];
    logic [7:0] b;
    logic [3:0] ea;
    logic       exp_bit;
    int dl, nre, ndone, done_at, tx_bad, first_bad, busy_bad;
    nre = 0; ndone = 0; done_at = -1; tx_bad = 0; first_bad = -1; busy_bad = 0;
    repeat (3) exp_tx.push_back(1'b1);
    for (int f = 0; f < int'(l); f++) begin
      b = d[8*f +: 8];
      repeat (CPB) exp_tx.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CPB) exp_tx.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      repeat (CPB) exp_tx.push_back(^b);
`endif
      repeat (CPB) exp_tx.push_back(1'b1);
      if (f < int'(l) - 1) begin
        exp_tx.push_back(1'b1);
        exp_tx.push_back(1'b1);
      end
    end
    dl = PERIOD * int'(l);

    @(negedge clk);
    start_addr = a;
    len        = l;
    start      = 1'b1;
    for (int k = 0; k < dl + 10; k++) begin
      @(negedge clk);
      start = (k == inj);
      if (k == inj) begin
        start_addr = a + 4'd5;
        len        = 5'd4;
      end
      if (k < 256) tx_log[k] = tx;
      exp_bit = (k < exp_tx.size()) ? exp_tx[k] : 1'b1;
      if (tx !== exp_bit) begin
        tx_bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (busy !== ((l != 0) && (k < dl))) busy_bad++;
      if (mem_re === 1'b1) begin
        ea = a + 4'(nre);
        chk($sformatf("%s raddr[%0d]", name, nre), int'(mem_raddr), int'(ea));
        nre++;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
    end
    start = 1'b0;
    chk($sformatf("%s tx bad cycles (first %0d)", name, first_bad), tx_bad, 0);
    chk($sformatf("%s mem_re count", name), nre, int'(l));
    chk($sformatf("%s done count", name), ndone, 1);
    chk($sformatf("%s done cycle", name), done_at, dl);
    chk($sformatf("%s busy bad cycles", name), busy_bad, 0);
    last_done_at = done_at;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    vecs[0] = '{addr: 4'd3,  len: 5'd1, data: 32'h0000_00A5, inj: -1};
    vecs[1] = '{addr: 4'd15, len: 5'd2, data: 32'h0000_8001, inj: -1};
    vecs[2] = '{addr: 4'd2,  len: 5'd0, data: 32'h0000_0000, inj: -1};
    vecs[3] = '{addr: 4'd0,  len: 5'd2, data: 32'h0000_C35A, inj: 20};
    vecs[4] = '{addr: 4'd7,  len: 5'd3, data: 32'h0000_FF3C, inj: -1};
    vecs[5] = '{addr: 4'd12, len: 5'd1, data: 32'h0000_0081, inj: -1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", int'(tx), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset mem_re", int'(mem_re), 0);
    chk("reset mem_raddr", int'(mem_raddr), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      load_mem(vecs[v].addr, vecs[v].len, vecs[v].data);
      run_xfer($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].data, vecs[v].inj);
    end

    // Hand-checked bit positions of a single 8'hA5 frame
    mem[3] = 8'hA5;
    run_xfer("a5", 4'd3, 5'd1, 32'h0000_00A5, -1);
    chk("a5 start bit", int'(tx_log[3]), 0);
    chk("a5 bit0", int'(tx_log[7]), 1);
    chk("a5 bit1", int'(tx_log[11]), 0);
`ifdef UART_TX_PARITY_EN
    chk("a5 parity", int'(tx_log[39]), 0);
    chk("a5 frame end", last_done_at, 46);
    mem[4] = 8'h07;
    run_xfer("p07", 4'd4, 5'd1, 32'h0000_0007, -1);
    chk("07 parity", int'(tx_log[39]), 1);
`else
    chk("a5 stop bit", int'(tx_log[39]), 1);
    chk("a5 frame end", last_done_at, 42);
`endif

    // Reset while a data bit of value 0 is on the line
    @(negedge clk);
    start_addr = 4'd3;
    len        = 5'd1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid busy before rst", int'(busy), 1);
    chk("mid tx before rst", int'(tx), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst tx", int'(tx), 1);
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst mem_re", int'(mem_re), 0);
    @(posedge clk);
    #1;
    chk("mid rst done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer("after_rst", 4'd3, 5'd1, 32'h0000_00A5, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
